div14_seq: RTL and testbench
============================

# div14_seq

Sequential 14-bit unsigned restoring divider, the inverse companion to the team's combinational carry-lookahead adder datapath. It computes the quotient and remainder by repeated trial subtraction, producing one quotient bit per clock, and sits behind valid/ready handshakes on both sides. The microcontroller ALU uses it for multi-cycle DIV/MOD instructions.

## Interface
- `WIDTH`, default 14: operand, quotient and remainder width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operands present on `dividend`/`divisor`.
- `in_ready` output 1: block can accept operands.
- `dividend` input WIDTH: unsigned numerator; sampled on the accept edge.
- `divisor` input WIDTH: unsigned denominator; sampled on the accept edge.
- `out_valid` output 1: result outputs are valid.
- `out_ready` input 1: consumer takes the result.
- `quotient` output WIDTH: unsigned quotient.
- `remainder` output WIDTH: unsigned remainder.
- `div_by_zero` output 1: the result came from a zero divisor.

## Operation
- The block has three states: IDLE, BUSY and DONE.
- **Accept:** happens on a rising edge with `in_valid & in_ready`. `in_ready` is 1 only in IDLE. It is combinational from state only.
- **IDLE → BUSY** on accept with `divisor != 0`:
  - R (WIDTH+1 bits) = 0.
  - Q = dividend.
  - D = divisor.
  - step counter = 0.
- **IDLE → DONE** on accept with `divisor == 0`:
  - quotient = all ones.
  - remainder = dividend.
  - `div_by_zero` = 1.
- **BUSY step** (one per edge):
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - S = T − {1'b0, D}, computed WIDTH+1 bits wide.
  - If there is no borrow (S MSB = 0): R = S and Q = {Q[WIDTH-2:0], 1}.
  - Otherwise: R = T and Q = {Q[WIDTH-2:0], 0}.
  - The counter increments.
- **BUSY → DONE** on the edge that performs step WIDTH (counter = WIDTH−1). That edge loads quotient = Q (post-shift), remainder = R[WIDTH-1:0] and `div_by_zero` = 0.
- **DONE:**
  - `out_valid` = 1, and `quotient`/`remainder`/`div_by_zero` hold stable until the handshake.
  - DONE → IDLE on the edge with `out_ready` = 1.
  - New operands are not accepted in the same cycle.
- **Inputs outside the accept edge:** `dividend`/`divisor` are ignored. Changing them during BUSY has no effect.
- **Reset (any state, including mid-BUSY):**
  - Returns to IDLE immediately. The in-flight operation is discarded.
  - `in_ready` = 1, `out_valid` = 0.
  - `quotient` = 0, `remainder` = 0, `div_by_zero` = 0.
  - Internal R, Q, D and the counter are cleared.
- **Counter width:** ceil(log2(WIDTH)) bits; it never wraps within an operation.

## Timing
- **Latency:** accept edge E0. `out_valid` rises after edge E_WIDTH (E14 for the default). Results are visible in the cycle following E14.
- **Zero divisor:** `out_valid` rises after E0, i.e. 1-edge latency.
- **Throughput:** at most one operation per WIDTH+2 cycles (accept, WIDTH steps, one DONE cycle minimum). `in_ready` returns the cycle after the `out_ready` handshake edge.
- **Backpressure:** `out_valid` stays 1 indefinitely while `out_ready` = 0, with outputs unchanged.
- **Combinational paths:** no input-to-output path. All outputs are registered or decoded from state.

## Structure
- Package `div_pkg`:
  - `DIV_WIDTH` = 14.
  - `div_state_t` enum {IDLE, BUSY, DONE}.
  - counter width localparam.
- Sub-module `sub_borrow`: WIDTH+1-bit subtractor returning the difference and borrow. It is implemented with carry-lookahead generate/propagate on A + ~B + 1, consistent with the existing adder blocks.
- Top level: FSM, counter, R/Q/D registers and result registers.

## Test plan
- **Basic:** dividend 100, divisor 7 → after 14 edges `out_valid`=1, quotient 14, remainder 2, `div_by_zero` 0.
- **Extremes:**
  - 16383 / 1 → quotient 16383, remainder 0.
  - 5 / 9 → quotient 0, remainder 5.
  - 16383 / 16383 → quotient 1, remainder 0.
- **Zero divisor:** 1234 / 0 → `out_valid` one edge after accept, quotient 0x3FFF, remainder 1234, `div_by_zero` 1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → outputs stable and `in_ready` stays 0. On release, `in_ready`=1 the next cycle.
- **Input isolation:** change `dividend`/`divisor` during BUSY, and assert `in_valid` during BUSY/DONE → result unaffected, no extra accept.
- **Reset mid-op:** assert `rst_n`=0 at step 7 → all outputs 0 and `in_ready`=1 immediately. A new 200 / 3 then returns 66 remainder 2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared width, state encoding and step-counter sizing for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 14;
  localparam int DIV_CNT_W = (DIV_WIDTH > 1) ? $clog2(DIV_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/sub_borrow.sv
// W-bit subtractor built as A + ~B + 1 with generate/propagate carries; borrow is the inverted carry-out.
module sub_borrow #(
  parameter int W = 15
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W-1:0] g, p;
  logic [W:0]   c;

  assign g    = a_i & ~b_i;
  assign p    = a_i ^ ~b_i;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_carry
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign diff_o   = p ^ c[W-1:0];
  assign borrow_o = ~c[W];

endmodule

// File: rtl/div14_seq.sv
// Restoring unsigned divider: one quotient bit per clock, valid/ready on both sides.
module div14_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // R never exceeds D-1 after a restoring step, so its top bit is always 0 and is not stored.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial, diff;
  logic             borrow, fits;

  assign trial = {r_q, q_q[WIDTH-1]};

  sub_borrow #(.W(WIDTH + 1)) u_sub (
    .a_i      (trial),
    .b_i      ({1'b0, d_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // Difference MSB and carry-out borrow both flag T < D.
  assign fits = ~(diff[WIDTH] | borrow);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            state_d = BUSY;
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        r_d   = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div14_seq.sv
// Scoreboard bench for div14_seq: expected results queued at accept, popped when out_valid rises.
module tb_div14_seq;

  localparam int W = 14;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  div14_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = W;
    end
    sb.push_back(e);
  endtask

  // Accept one operation, wait for the result, check it, hold off out_ready for bp cycles, then drain.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int bp, input bit perturb);
    exp_t e;
    int   lat;
    chk("in_ready_pre", in_ready, 1);
    in_valid = 1'b1; dividend = a; divisor = b;
    push_exp(a, b);
    @(posedge clk); #1;
    in_valid = perturb;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (perturb) begin
        dividend = W'($urandom); divisor = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("in_ready_done", in_ready, 0);
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", div_by_zero, e.dbz);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_quotient", quotient, e.q);
      chk("bp_remainder", remainder, e.r);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_post", in_ready, 1);
    chk("out_valid_post", out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(14'd100,   14'd7,     0, 1'b0);
    do_op(14'd16383, 14'd1,     0, 1'b0);
    do_op(14'd5,     14'd9,     0, 1'b0);
    do_op(14'd16383, 14'd16383, 0, 1'b0);
    do_op(14'd1234,  14'd0,     0, 1'b0);
    do_op(14'd100,   14'd7,    10, 1'b0);
    do_op(14'd9999,  14'd37,    0, 1'b1);
    do_op(14'd77,    14'd0,     3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(1, 300));
      do_op(ra, rb, k % 3, k[0]);
    end

    // Abort mid-operation: reset lands during step 7.
    in_valid = 1'b1; dividend = 14'd1000; divisor = 14'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_quotient", quotient, 0);
    chk("mid_rst_remainder", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", out_valid, 0);
    do_op(14'd200, 14'd3, 0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
